// File: rtl/udp_tx_packetizer.sv
// Packs 32-bit records from the return FIFO byte stream into UDP payload packets.
// Optional per-packet sequence header byte: define TX_PKT_SEQ_HDR_EN.
module udp_tx_packetizer #(
    parameter int MAX_RECORDS  = 16,
    parameter int IDLE_TIMEOUT = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_fifo_tdata,
    input  logic        s_fifo_tvalid,
    output logic        s_fifo_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] pkt_count
);

    localparam int LAST_IDX = 4 * MAX_RECORDS - 1;
    localparam int IDX_W    = $clog2(4 * MAX_RECORDS);
    localparam int CNT_W    = $clog2(IDLE_TIMEOUT + 1);

`ifdef TX_PKT_SEQ_HDR_EN
    typedef enum logic [1:0] {IDLE, HDR, FILL, CLOSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, CLOSE} state_t;
`endif

    state_t             state, state_nxt;
    logic [7:0]         p_data;
    logic               p_valid;
    logic [IDX_W-1:0]   byte_idx;
    logic [CNT_W-1:0]   idle_cnt;
`ifdef TX_PKT_SEQ_HDR_EN
    logic [7:0]         seq;
    logic               load_hdr;
`endif

    logic rdy;
    logic accept;
    logic handshake;
    logic out_free;
    logic p_last;
    logic timeout_hit;
    logic move_p;
    logic move_last;

    assign handshake = m_axis_tvalid & m_axis_tready;
    assign out_free  = ~m_axis_tvalid | m_axis_tready;
    assign accept    = s_fifo_tready & s_fifo_tvalid;
    assign p_last    = p_valid && (byte_idx == IDX_W'(LAST_IDX));
    // idle_cnt excludes the current cycle, so the hit fires on the IDLE_TIMEOUT-th idle cycle
    assign timeout_hit = (state == FILL) && p_valid && (byte_idx[1:0] == 2'b11) &&
                         (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin : next_state
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef TX_PKT_SEQ_HDR_EN
                if (s_fifo_tvalid) state_nxt = HDR;
`else
                if (accept) state_nxt = FILL;
`endif
            end
`ifdef TX_PKT_SEQ_HDR_EN
            HDR:   if (handshake) state_nxt = FILL;
`endif
            FILL:  if (p_valid && (p_last || (timeout_hit && !accept))) state_nxt = CLOSE;
            CLOSE: if (handshake && m_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : out_comb
        rdy       = 1'b0;
        move_p    = 1'b0;
        move_last = 1'b0;
`ifdef TX_PKT_SEQ_HDR_EN
        load_hdr  = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef TX_PKT_SEQ_HDR_EN
                load_hdr = s_fifo_tvalid;
`else
                rdy = 1'b1;
`endif
            end
            FILL: begin
                rdy = !p_valid || (out_free && !p_last);
                // with P held and the output free, rdy is high, so tvalid alone means accept
                if (p_valid && out_free) begin
                    if (p_last) begin
                        move_p    = 1'b1;
                        move_last = 1'b1;
                    end else if (s_fifo_tvalid) begin
                        move_p    = 1'b1;
                    end else if (timeout_hit) begin
                        move_p    = 1'b1;
                        move_last = 1'b1;
                    end
                end
            end
            CLOSE: begin
                if (p_valid && out_free) begin
                    move_p    = 1'b1;
                    move_last = 1'b1;
                end
            end
            default: ;
        endcase
        s_fifo_tready = rdy & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin : datapath
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            p_data        <= '0;
            p_valid       <= 1'b0;
            byte_idx      <= '0;
            idle_cnt      <= '0;
            pkt_count     <= '0;
`ifdef TX_PKT_SEQ_HDR_EN
            seq           <= '0;
`endif
        end else begin
            if (handshake) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
`ifdef TX_PKT_SEQ_HDR_EN
            if (load_hdr) begin
                m_axis_tdata  <= seq;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b0;
            end
`endif
            if (move_p) begin
                m_axis_tdata  <= p_data;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= move_last;
                p_valid       <= 1'b0;
            end
            if (accept) begin
                p_data   <= s_fifo_tdata;
                p_valid  <= 1'b1;
                byte_idx <= (state == IDLE || !p_valid) ? '0 : byte_idx + IDX_W'(1);
            end

            if (state != FILL || accept)
                idle_cnt <= '0;
            else if (idle_cnt != CNT_W'(IDLE_TIMEOUT - 1))
                idle_cnt <= idle_cnt + CNT_W'(1);

            if (handshake && m_axis_tlast) begin
                pkt_count <= pkt_count + 16'd1;
`ifdef TX_PKT_SEQ_HDR_EN
                seq       <= seq + 8'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Randomized bench for udp_tx_packetizer; expected packets are built from the bytes offered.
module tb_udp_tx_packetizer;

    localparam int MAXR      = 16;
    localparam int TO        = 250;
    localparam int PKT_BYTES = 4 * MAXR;
`ifdef TX_PKT_SEQ_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_fifo_tdata;
    logic        s_fifo_tvalid;
    logic        s_fifo_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] pkt_count;

    udp_tx_packetizer #(.MAX_RECORDS(MAXR), .IDLE_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_fifo_tdata  (s_fifo_tdata),
        .s_fifo_tvalid (s_fifo_tvalid),
        .s_fifo_tready (s_fifo_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] mdl_seq;
    logic [15:0] mdl_pkts;
    bit         force1 = 1'b0;
    bit         force0 = 1'b0;
    bit         lat_arm = 1'b0;
    int         first_valid_cyc = -1;
    int         acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // output-side sink readiness
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_axis_tready = force1 ? 1'b1 : (force0 ? 1'b0 : ($urandom_range(0, 3) != 0));
        end
    end

    // output monitor: ordering against the expected stream and AXI hold rules
    initial begin
        logic       pv, pr, pl;
        logic [7:0] pd;
        logic [8:0] e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", m_axis_tvalid, 1);
                    check("hold_data", m_axis_tdata, pd);
                    check("hold_last", m_axis_tlast, pl);
                end
                if (lat_arm && m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (m_axis_tvalid && m_axis_tready) begin
                    check("out_expected_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_data", m_axis_tdata, e[7:0]);
                        check("out_last", m_axis_tlast, e[8]);
                    end
                end
                pv = m_axis_tvalid; pr = m_axis_tready;
                pd = m_axis_tdata;  pl = m_axis_tlast;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input int gap, output bit ok);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_fifo_tdata  = d;
        s_fifo_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (s_fifo_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("fifo_ready_wait", s_fifo_tready, 1);
        @(posedge clk);
        #1;
        acc_cyc       = cyc;
        s_fifo_tvalid = 1'b0;
    endtask

    // sends pay_q as one packet; a full packet closes at once, a short one after the idle timeout
    task automatic send_pkt(input int long_gap_at, input bit rnd);
        int n;
        int gap;
        int t0;
        bit full;
        bit ok;
        bit seen;
        n    = pay_q.size();
        full = (n == PKT_BYTES);
        if (HDR) exp_q.push_back({1'b0, mdl_seq});
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pay_q[i]});
        for (int i = 0; i < n; i++) begin
            if (i == long_gap_at)                      gap = 1000;
            else if (rnd && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 4);
            else                                       gap = 0;
            send_byte(pay_q[i], gap, ok);
        end
        force1 = 1'b1;
        t0     = acc_cyc;
        seen   = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tlast) begin
                seen = 1'b1;
                break;
            end
        end
        check(full ? "tlast_delay_full" : "tlast_delay_timeout",
              seen ? (cyc - t0) : 32'hFFFF_FFFF, full ? 1 : TO);
        mdl_seq  = mdl_seq + 8'd1;
        mdl_pkts = mdl_pkts + 16'd1;
        @(negedge clk);
        check("pkt_count", pkt_count, mdl_pkts);
        @(posedge clk);
        #1;
        force1 = 1'b0;
        pay_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  lat_c0;
        int  nrec;
        bit  ok;
        rst           = 1'b1;
        s_fifo_tvalid = 1'b0;
        s_fifo_tdata  = '0;
        mdl_seq       = '0;
        mdl_pkts      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_fifo_tready", s_fifo_tready, 0);
        check("rst_pkt_count", pkt_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // short record, timeout close, first-output latency
        pay_q = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        lat_c0 = cyc;
        first_valid_cyc = -1;
        lat_arm = 1'b1;
        send_pkt(-1, 1'b0);
        lat_arm = 1'b0;
        check("first_valid_latency", first_valid_cyc - lat_c0, HDR ? 1 : 2);

        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt(-1, 1'b1);

        // long stall mid-record must not close the packet
        pay_q = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        send_pkt(2, 1'b0);

        // 17 records: one full packet, then a one-record packet
        for (int i = 0; i < PKT_BYTES; i++) pay_q.push_back(8'(i * 7 + 1));
        send_pkt(-1, 1'b0);
        pay_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
        send_pkt(-1, 1'b0);

        // output backpressure while a full packet streams in
        for (int i = 0; i < PKT_BYTES; i++) pay_q.push_back(8'($urandom));
        fork
            send_pkt(-1, 1'b0);
            begin
                repeat (20) @(posedge clk);
                #1;
                force0 = 1'b1;
                repeat (10) @(negedge clk);
                check("fifo_ready_in_stall", s_fifo_tready, 0);
                @(posedge clk);
                #1;
                force0 = 1'b0;
            end
        join

        for (int p = 0; p < 10; p++) begin
            nrec = $urandom_range(1, MAXR);
            for (int i = 0; i < 4 * nrec; i++) pay_q.push_back(8'($urandom));
            send_pkt(-1, 1'b1);
        end

        // reset in the middle of a packet
        force1 = 1'b1;
        if (HDR) exp_q.push_back({1'b0, mdl_seq});
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({1'b0, 8'(8'h80 + i)});
            send_byte(8'(8'h80 + i), 0, ok);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_tlast", m_axis_tlast, 0);
        check("midrst_tdata", m_axis_tdata, 0);
        check("midrst_fifo_tready", s_fifo_tready, 0);
        check("midrst_pkt_count", pkt_count, 0);
        repeat (2) @(posedge clk);
        exp_q.delete();
        mdl_seq  = '0;
        mdl_pkts = '0;
        force1   = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("pkt_count_after_rst", pkt_count, mdl_pkts);
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt(-1, 1'b1);

        repeat (5) @(posedge clk);
        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/udp_tx_packetizer.md
UDP_TX_PACKETIZER -- requirements
Module: udp_tx_packetizer

Interface
REQ-001 SHALL have parameter MAX_RECORDS, default 16: 32-bit records per packet before forced close.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 250: clk cycles of input idleness before a partial packet closes.
REQ-003 SHALL have port clk  input  1  packet clock, 125 MHz network side.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_fifo_tdata  input  8  byte from the return FIFO (FWFT).
REQ-006 SHALL have port s_fifo_tvalid  input  1  return FIFO not empty.
REQ-007 SHALL have port s_fifo_tready  output  1  FIFO read enable; a byte is accepted when tvalid and tready are both high.
REQ-008 SHALL have port m_axis_tdata  output  8  byte to the UDP TX engine.
REQ-009 SHALL have port m_axis_tvalid  output  1  output byte valid.
REQ-010 SHALL have port m_axis_tlast  output  1  last byte of the packet.
REQ-011 SHALL have port m_axis_tready  input  1  UDP TX engine ready.
REQ-012 SHALL have port pkt_count  output  16  packets completed, wrapping.

Function
REQ-013 SHALL implement states IDLE, HDR, FILL and CLOSE.
REQ-014 SHALL hold at most one pending byte P internally; P is released to the output only once it is known whether P is the packet's last byte.
REQ-015 SHALL keep byte_idx, counting payload bytes accepted in the current packet (0..4*MAX_RECORDS-1).
REQ-016 IDLE: on s_fifo_tvalid, SHALL go to HDR if the header feature is compiled in, else accept the byte into P and go to FILL.
REQ-017 HDR: SHALL present the sequence byte seq on the output and go to FILL when that byte handshakes.
REQ-018 FILL: SHALL move P to the output with tlast=0 whenever the output is free (tvalid low, or tready high) and a new FIFO byte is accepted into P that same cycle.
REQ-019 SHALL emit the byte with byte_idx = 4*MAX_RECORDS-1 with tlast=1 straight away, without waiting for a following byte.
REQ-020 Timeout: SHALL count consecutive FILL cycles in which no byte is accepted, clearing the count on any accept.
REQ-021 When the timeout count reaches IDLE_TIMEOUT and P is at a record boundary (byte_idx mod 4 = 3), SHALL go to CLOSE and emit P with tlast=1.
REQ-022 SHALL never time out mid-record; it waits indefinitely instead.
REQ-023 s_fifo_tready SHALL be high only when P is empty or P is leaving this cycle, and SHALL be low in HDR and CLOSE.
REQ-024 m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL be registered and held stable while tvalid=1 and tready=0 (AXI-stream rules).
REQ-025 On a handshake of a tlast=1 byte, SHALL increment pkt_count and seq (8-bit wrap, 0xFF->0x00) and return to IDLE.
REQ-026 A timeout expiry coinciding with a byte accept SHALL not close; the accept wins.
REQ-027 No byte SHALL ever be dropped or duplicated; backpressure propagates to the FIFO only.
REQ-028 Latency, IDLE to first output valid, SHALL be 1 cycle with the header and 2 cycles without it.

Reset
REQ-029 rst high SHALL asynchronously force state IDLE and clear P, byte_idx, the timeout count, seq and pkt_count.
REQ-030 rst high SHALL asynchronously drive m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0x00 and s_fifo_tready=0.
REQ-031 Reset mid-packet SHALL abandon that packet without emitting tlast; the first packet after reset SHALL carry seq 0x00.

Configuration
REQ-032 With macro TX_PKT_SEQ_HDR_EN defined, every packet SHALL begin with one seq header byte, so a full packet is 4*MAX_RECORDS+1 bytes.
REQ-033 With TX_PKT_SEQ_HDR_EN undefined, state HDR and seq SHALL be absent and packets SHALL contain payload only.

Verification
REQ-034 Header on, tready=1, bytes DD,CC,BB,AA then idle -> output 00,DD,CC,BB,AA; tlast on AA exactly 250 cycles after AA is accepted; pkt_count=1.
REQ-035 Header on, 17 records back-to-back -> first packet is 65 bytes with tlast on byte 65 and no timeout wait; second packet starts with header 01.
REQ-036 m_axis_tready low for 10 cycles mid-packet -> tdata/tlast stable, s_fifo_tready low once P is full, full byte sequence intact afterwards.
REQ-037 Two bytes then FIFO empty for 1000 cycles -> no tlast; after the remaining two bytes, tlast appears 250 cycles later.
REQ-038 Assert rst mid-packet -> all outputs 0 immediately; next packet header 00 and pkt_count 0.
REQ-039 Header off, one record 11,22,33,44 -> output exactly 11,22,33,44 with tlast on 44.
